// File: rtl/alu_arbiter.sv
// Round-robin two-port arbiter and sequencer for a shared 16-bit combinational ALU.
// Registers operands/ctrl toward the ALU, captures its result and returns a tagged response.
module alu_arbiter #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned WIDTH      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  localparam logic [2:0] OpMul = 3'b001;
  localparam logic [2:0] OpShl = 3'b010;
  localparam logic [2:0] OpXor = 3'b011;
  localparam logic [2:0] OpAdd = 3'b100;
  localparam logic [3:0] MulLoad = 4'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_ctrl_q, alu_ctrl_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic             any_valid;
  logic             gnt_id;
  logic             op_legal;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Contention goes to the requester that did not win last; a lone requester always wins.
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    gnt_id     = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready = (state_q == StIdle) & any_valid & ~gnt_id;
    req1_ready = (state_q == StIdle) & any_valid & gnt_id;
    sel_op     = gnt_id ? req1_op : req0_op;
    sel_a      = gnt_id ? req1_a : req0_a;
    sel_b      = gnt_id ? req1_b : req0_b;
    case (sel_op)
      OpMul, OpShl, OpXor, OpAdd: op_legal = 1'b1;
      default:                    op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    id_d         = id_q;
    result_d     = result_q;
    zero_d       = zero_q;
    err_d        = err_q;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          last_grant_d = gnt_id;
          id_d         = gnt_id;
          if (op_legal) begin
            alu_a_d    = sel_a;
            alu_b_d    = sel_b;
            alu_ctrl_d = sel_op;
            cnt_d      = (sel_op == OpMul) ? MulLoad : 4'd0;
            state_d    = StExec;
          end else begin
            // Illegal ops never reach the ALU; answer directly with an error.
            result_d = '0;
            zero_d   = 1'b1;
            err_d    = 1'b1;
            state_d  = StResp;
          end
        end
      end
      StExec: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d = alu_result;
          zero_d   = alu_zero;
          err_d    = 1'b0;
          state_d  = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= 3'b000;
      id_q         <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      id_q         <= id_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    rsp_valid  = (state_q == StResp);
    busy       = (state_q != StIdle);
    rsp_id     = id_q;
    rsp_result = result_q;
    rsp_zero   = zero_q;
    rsp_err    = err_q;
    alu_a      = alu_a_q;
    alu_b      = alu_b_q;
    alu_ctrl   = alu_ctrl_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU; vector table plus multi-cycle sequences.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
  logic [15:0] rsp_result, alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic        alu_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.MUL_CYCLES(3), .WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  // Behavioural model of the shared ALU.
  always_comb begin
    case (alu_ctrl)
      3'b001:  alu_result = {8'h00, alu_a[7:0]} * {8'h00, alu_b[7:0]};
      3'b010:  alu_result = (alu_b >= 16'd16) ? 16'h0000 : (alu_a << alu_b[3:0]);
      3'b011:  alu_result = alu_a ^ alu_b;
      3'b100:  alu_result = alu_a + alu_b;
      default: alu_result = 16'h0000;
    endcase
    alu_zero = (alu_result == 16'h0000);
  end

  // A requester left waiting must keep its op stable.
  logic        p0_stall = 1'b0, p1_stall = 1'b0;
  logic [34:0] p0_hold, p1_hold;
  always @(posedge clk) begin
    if (p0_stall && req0_valid) begin
      checks++;
      if ({req0_op, req0_a, req0_b} != p0_hold) begin
        errors++;
        $display("FAIL req0_stable actual=%h required=%h", {req0_op, req0_a, req0_b}, p0_hold);
      end
    end
    if (p1_stall && req1_valid) begin
      checks++;
      if ({req1_op, req1_a, req1_b} != p1_hold) begin
        errors++;
        $display("FAIL req1_stable actual=%h required=%h", {req1_op, req1_a, req1_b}, p1_hold);
      end
    end
    p0_stall <= req0_valid && !req0_ready;
    p1_stall <= req1_valid && !req1_ready;
    p0_hold  <= {req0_op, req0_a, req0_b};
    p1_hold  <= {req1_op, req1_a, req1_b};
  end

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        zero;
    logic        err;
    int          lat;
  } vec_t;

  vec_t       vecs[12];
  logic [2:0] exp_ctrl;

  function automatic vec_t mk(input logic id, input logic [2:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] res, input logic zero,
                              input logic err, input int lat);
    vec_t v;
    v.id = id; v.op = op; v.a = a; v.b = b; v.res = res; v.zero = zero; v.err = err; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic id, input logic v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    if (id) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input logic id, output logic ok);
    int n = 0;
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      tick();
      n++;
    end
    ok = id ? req1_ready : req0_ready;
    if (!ok) chk("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!rsp_valid && n < 30) begin
      tick();
      n++;
    end
    if (!rsp_valid) chk(name, 32'd0, 32'd1);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    logic ok;
    int   n;
    drive(v.id, 1'b1, v.op, v.a, v.b);
    wait_ready(v.id, ok);
    if (!ok) begin
      drive(v.id, 1'b0, 3'b000, 16'h0, 16'h0);
      return;
    end
    tick();
    drive(v.id, 1'b0, 3'b000, 16'h0, 16'h0);
    n = 1;
    while (!rsp_valid && n < 30) begin
      chk("hold_a", alu_a, v.a);
      chk("hold_b", alu_b, v.b);
      chk("hold_ctrl", alu_ctrl, v.op);
      tick();
      n++;
    end
    chk("latency", n, v.lat);
    chk("rsp_id", rsp_id, v.id);
    chk("rsp_result", rsp_result, v.res);
    chk("rsp_zero", rsp_zero, v.zero);
    chk("rsp_err", rsp_err, v.err);
    if (v.err) chk("ctrl_unchanged", alu_ctrl, exp_ctrl);
    else exp_ctrl = v.op;
    tick();
    chk("idle_after_rsp", {busy, rsp_valid}, 2'b00);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    vecs[0]  = mk(1'b0, 3'b100, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 2);
    vecs[1]  = mk(1'b1, 3'b001, 16'h1234, 16'h0056, 16'h1178, 1'b0, 1'b0, 4);
    vecs[2]  = mk(1'b0, 3'b011, 16'hA5A5, 16'hA5A5, 16'h0000, 1'b1, 1'b0, 2);
    vecs[3]  = mk(1'b1, 3'b010, 16'h0001, 16'h0004, 16'h0010, 1'b0, 1'b0, 2);
    vecs[4]  = mk(1'b0, 3'b110, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1'b1, 1);
    vecs[5]  = mk(1'b1, 3'b010, 16'h8001, 16'h0010, 16'h0000, 1'b1, 1'b0, 2);
    vecs[6]  = mk(1'b0, 3'b001, 16'hABFF, 16'hCDFF, 16'hFE01, 1'b0, 1'b0, 4);
    vecs[7]  = mk(1'b1, 3'b000, 16'h0F0F, 16'h0001, 16'h0000, 1'b1, 1'b1, 1);
    vecs[8]  = mk(1'b0, 3'b100, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 2);
    vecs[9]  = mk(1'b1, 3'b011, 16'h00FF, 16'hFF00, 16'hFFFF, 1'b0, 1'b0, 2);
    vecs[10] = mk(1'b0, 3'b111, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b1, 1);
    vecs[11] = mk(1'b1, 3'b010, 16'h00FF, 16'h000F, 16'h8000, 1'b0, 1'b0, 2);

    rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 3'b000, 16'h0, 16'h0);
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_rsp", {rsp_valid, rsp_id, rsp_zero, rsp_err}, 4'b0000);
    chk("reset_result", rsp_result, 16'h0000);
    chk("reset_alu", {alu_ctrl, alu_a, alu_b}, 35'h0);
    chk("reset_ready", {req0_ready, req1_ready}, 2'b00);
    rst_n = 1'b1;
    exp_ctrl = 3'b000;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Both requesters valid continuously: grants must alternate starting at req0.
    do_reset();
    drive(1'b0, 1'b1, 3'b011, 16'hA5A5, 16'hA5A5);
    drive(1'b1, 1'b1, 3'b010, 16'h0001, 16'h0004);
    for (int k = 0; k < 4; k++) begin
      wait_rsp("rr_timeout");
      chk("rr_id", rsp_id, k[0]);
      chk("rr_result", rsp_result, k[0] ? 16'h0010 : 16'h0000);
      chk("rr_zero", rsp_zero, !k[0]);
      tick();
    end
    drive(1'b0, 1'b0, 3'b000, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 3'b000, 16'h0, 16'h0);
    tick();

    // Response backpressure.
    rsp_ready = 1'b0;
    drive(1'b1, 1'b1, 3'b100, 16'h0003, 16'h0004);
    wait_ready(1'b1, ok);
    tick();
    drive(1'b1, 1'b0, 3'b000, 16'h0, 16'h0);
    wait_rsp("bp_timeout");
    drive(1'b0, 1'b1, 3'b011, 16'h1111, 16'h2222);
    drive(1'b1, 1'b1, 3'b011, 16'h3333, 16'h4444);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid_busy", {rsp_valid, busy}, 2'b11);
      chk("bp_result", rsp_result, 16'h0007);
      chk("bp_id_zero_err", {rsp_id, rsp_zero, rsp_err}, 3'b100);
      chk("bp_ready", {req0_ready, req1_ready}, 2'b00);
      tick();
    end
    drive(1'b0, 1'b0, 3'b000, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 3'b000, 16'h0, 16'h0);
    rsp_ready = 1'b1;
    tick();
    chk("bp_release", {busy, rsp_valid}, 2'b00);

    // Reset in the second EXEC cycle of a multiply drops the op.
    drive(1'b1, 1'b1, 3'b001, 16'h0002, 16'h0003);
    wait_ready(1'b1, ok);
    tick();
    drive(1'b1, 1'b0, 3'b000, 16'h0, 16'h0);
    tick();
    chk("mid_busy", {busy, rsp_valid}, 2'b10);
    rst_n = 1'b0;
    tick();
    chk("mid_reset_state", {busy, rsp_valid}, 2'b00);
    chk("mid_reset_ctrl", alu_ctrl, 3'b000);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 3'b100, 16'h0005, 16'h0006);
    drive(1'b1, 1'b1, 3'b100, 16'h0007, 16'h0008);
    #1;
    chk("post_reset_grant", {req0_ready, req1_ready}, 2'b10);
    tick();
    drive(1'b0, 1'b0, 3'b000, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 3'b000, 16'h0, 16'h0);
    wait_rsp("post_reset_timeout");
    chk("post_reset_id", rsp_id, 1'b0);
    chk("post_reset_result", rsp_result, 16'h000B);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
